// File: rtl/slot_bus_pkg.sv
// Shared definitions for the peripheral slot bus controller.
//
// Contents:
//   - the four I/O bank numbers that can carry slot space
//   - address bounds of the DEVSEL, IOSEL and IOSTROBE regions
//   - the select-kind enum shared by the decoder and the strobe generator
//   - helpers that size the hold counter and mask off invalid slot numbers
package slot_bus_pkg;

    localparam int SLOT_W = 3;

    localparam logic [7:0] BANK_00 = 8'h00;
    localparam logic [7:0] BANK_01 = 8'h01;
    localparam logic [7:0] BANK_E0 = 8'hE0;
    localparam logic [7:0] BANK_E1 = 8'hE1;

    localparam logic [15:0] ADDR_DEV_LO = 16'hC090;
    localparam logic [15:0] ADDR_IO_LO  = 16'hC100;
    localparam logic [15:0] ADDR_STB_LO = 16'hC800;
    localparam logic [15:0] ADDR_CFFF   = 16'hCFFF;

    typedef enum logic [1:0] {
        SEL_DEV = 2'd0,
        SEL_IO  = 2'd1,
        SEL_STB = 2'd2
    } sel_kind_e;

    // The counter must hold STROBE_LEN itself, so it needs clog2(len+1) bits.
    function automatic int strobe_cnt_width(input int len);
        return (len < 2) ? 1 : $clog2(len + 1);
    endfunction

    // Slot numbers that can ever hold a card: below nSlots and never slot 0.
    function automatic logic [7:0] slot_range_mask(input int nSlots);
        logic [7:0] m;
        m = '0;
        for (int i = 1; i < 8; i++) begin
            m[i] = (i < nSlots);
        end
        return m;
    endfunction

endpackage

// File: rtl/slot_strobe_gen.sv
// Hold counter plus one-hot select register shared by all three select kinds.
//
// Ports:
//   i_clk, i_reset_n   clock and synchronous active-low reset
//   i_start            qualifying access this cycle; (re)starts the pulse
//   i_kind, i_slot     which select vector and which slot the new pulse drives
//   i_read             the starting access is a read
//   o_dev/o_io/o_stb   one-hot select outputs (at most one bit high overall)
//   o_cap              capture read data at this edge (entering the final cycle)
//   o_cap_slot         slot whose data is captured
module slot_strobe_gen
    import slot_bus_pkg::*;
#(
    parameter int NSLOTS     = 8,
    parameter int STROBE_LEN = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  sel_kind_e         i_kind,
    input  logic [SLOT_W-1:0] i_slot,
    input  logic              i_read,
    output logic [NSLOTS-1:0] o_dev,
    output logic [NSLOTS-1:0] o_io,
    output logic [NSLOTS-1:0] o_stb,
    output logic              o_cap,
    output logic [SLOT_W-1:0] o_cap_slot
);

    localparam int CW = strobe_cnt_width(STROBE_LEN);
    localparam logic [CW-1:0] LEN = CW'(STROBE_LEN);

    logic [CW-1:0]     r_holdCnt;
    logic [CW-1:0]     w_holdCntNxt;
    sel_kind_e         r_kind;
    logic [SLOT_W-1:0] r_slot;
    logic              r_read;
    logic [NSLOTS-1:0] w_oneHot;

    // A new access always wins over a running pulse, which is how truncation works.
    always_comb begin
        w_holdCntNxt = r_holdCnt;
        if (i_start) begin
            w_holdCntNxt = LEN;
        end else if (r_holdCnt != '0) begin
            w_holdCntNxt = r_holdCnt - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_holdCnt <= '0;
            r_kind    <= SEL_DEV;
            r_slot    <= '0;
            r_read    <= 1'b0;
        end else begin
            r_holdCnt <= w_holdCntNxt;
            if (i_start) begin
                r_kind <= i_kind;
                r_slot <= i_slot;
                r_read <= i_read;
            end
        end
    end

    // The counter being nonzero is the pulse; kind routes it to one vector only.
    always_comb begin
        for (int i = 0; i < NSLOTS; i++) begin
            w_oneHot[i] = (r_holdCnt != '0) && (r_slot == SLOT_W'(i));
        end
        o_dev = (r_kind == SEL_DEV) ? w_oneHot : '0;
        o_io  = (r_kind == SEL_IO)  ? w_oneHot : '0;
        o_stb = (r_kind == SEL_STB) ? w_oneHot : '0;
    end

    // Read data is taken on the edge that enters the last pulse cycle, so a
    // pulse cut short by a newer access never reports data.
    always_comb begin
        o_cap      = (w_holdCntNxt == CW'(1)) && (i_start ? i_read : r_read);
        o_cap_slot = i_start ? i_slot : r_slot;
    end

endmodule

// File: rtl/slot_bus_ctrl.sv
// Apple II-style peripheral slot controller for the IIgs core.
// Decodes CPU accesses to slot I/O space, produces timed DEVSEL / IOSEL /
// IOSTROBE pulses, tracks $C800 expansion-ROM ownership and returns card data.
//
// Ports:
//   i_clk_sys, i_reset_n        system clock, synchronous active-low reset
//   i_phase_ce                  CPU access qualifier
//   i_bank, i_addr, i_we        CPU bank, address, write flag
//   i_sltromsel, i_intcxrom     external-ROM select per slot, internal-ROM force
//   i_slot_rdata                packed card read data, 8 bits per slot
//   o_device_select/o_io_select/o_io_strobe   per-slot select pulses
//   o_int_rom_ce, o_slot_ce     combinational internal-ROM / external-card enables
//   o_exp_owner, o_exp_valid    current $C800 owner
//   o_rdata, o_rdata_valid      registered read data and its one-cycle strobe
module slot_bus_ctrl
    import slot_bus_pkg::*;
#(
    parameter int                NSLOTS     = 8,
    parameter logic [NSLOTS-1:0] SLOT_MASK  = 8'hFE,
    parameter int                STROBE_LEN = 2
) (
    input  logic                  i_clk_sys,
    input  logic                  i_reset_n,
    input  logic                  i_phase_ce,
    input  logic [7:0]            i_bank,
    input  logic [15:0]           i_addr,
    input  logic                  i_we,
    input  logic [7:0]            i_sltromsel,
    input  logic                  i_intcxrom,
    input  logic [8*NSLOTS-1:0]   i_slot_rdata,
    output logic [NSLOTS-1:0]     o_device_select,
    output logic [NSLOTS-1:0]     o_io_select,
    output logic [NSLOTS-1:0]     o_io_strobe,
    output logic                  o_int_rom_ce,
    output logic                  o_slot_ce,
    output logic [2:0]            o_exp_owner,
    output logic                  o_exp_valid,
    output logic [7:0]            o_rdata,
    output logic                  o_rdata_valid
);

    localparam logic [7:0] POS_MASK = slot_range_mask(NSLOTS);

    logic              w_ioBank;
    logic              w_inDev;
    logic              w_inIo;
    logic              w_inStb;
    logic              w_cfffHit;
    logic [7:0]        w_ext;
    logic [SLOT_W-1:0] w_devSlot;
    logic [SLOT_W-1:0] w_ioSlot;
    logic              w_start;
    sel_kind_e         w_kind;
    logic [SLOT_W-1:0] w_slot;
    logic              w_cap;
    logic [SLOT_W-1:0] w_capSlot;
    logic [7:0]        w_capByte;

    logic [2:0]        r_expOwner;
    logic              r_expValid;
    logic [7:0]        r_rdata;
    logic              r_rdataValid;

    // Region membership; nothing decodes outside the four I/O banks.
    always_comb begin
        w_ioBank  = (i_bank == BANK_00) || (i_bank == BANK_01) ||
                    (i_bank == BANK_E0) || (i_bank == BANK_E1);
        w_inDev   = w_ioBank && (i_addr >= ADDR_DEV_LO) && (i_addr < ADDR_IO_LO);
        w_inIo    = w_ioBank && (i_addr >= ADDR_IO_LO) && (i_addr < ADDR_STB_LO);
        w_inStb   = w_ioBank && (i_addr >= ADDR_STB_LO) && (i_addr <= ADDR_CFFF);
        w_cfffHit = i_phase_ce && w_ioBank && (i_addr == ADDR_CFFF);
        w_ext     = 8'(SLOT_MASK) & i_sltromsel & POS_MASK;
        w_devSlot = i_addr[6:4];
        w_ioSlot  = i_addr[10:8];
    end

    // Claim decision. The chip enables follow the address alone; only the
    // strobe start is qualified by phase_ce.
    always_comb begin
        w_start      = 1'b0;
        w_kind       = SEL_DEV;
        w_slot       = '0;
        o_int_rom_ce = 1'b0;
        o_slot_ce    = 1'b0;
        if (w_inDev) begin
            if (w_ext[w_devSlot]) begin
                o_slot_ce = 1'b1;
                w_start   = i_phase_ce;
                w_kind    = SEL_DEV;
                w_slot    = w_devSlot;
            end
        end else if (w_inIo) begin
            if (!i_intcxrom && w_ext[w_ioSlot]) begin
                o_slot_ce = 1'b1;
                w_start   = i_phase_ce;
                w_kind    = SEL_IO;
                w_slot    = w_ioSlot;
            end else begin
                o_int_rom_ce = 1'b1;
            end
        end else if (w_inStb) begin
            if (!i_intcxrom && r_expValid && w_ext[r_expOwner]) begin
                o_slot_ce = 1'b1;
                w_start   = i_phase_ce;
                w_kind    = SEL_STB;
                w_slot    = r_expOwner;
            end else begin
                o_int_rom_ce = 1'b1;
            end
        end
    end

    slot_strobe_gen #(
        .NSLOTS     (NSLOTS),
        .STROBE_LEN (STROBE_LEN)
    ) u_strobeGen (
        .i_clk      (i_clk_sys),
        .i_reset_n  (i_reset_n),
        .i_start    (w_start),
        .i_kind     (w_kind),
        .i_slot     (w_slot),
        .i_read     (!i_we),
        .o_dev      (o_device_select),
        .o_io       (o_io_select),
        .o_stb      (o_io_strobe),
        .o_cap      (w_cap),
        .o_cap_slot (w_capSlot)
    );

    // A $CFFF access is serviced by the old owner first (the decode above
    // uses the current register), then ownership drops on the same edge.
    always_ff @(posedge i_clk_sys) begin
        if (!i_reset_n) begin
            r_expOwner <= '0;
            r_expValid <= 1'b0;
        end else if (w_start && (w_kind == SEL_IO)) begin
            r_expOwner <= w_slot;
            r_expValid <= 1'b1;
        end else if (w_cfffHit) begin
            r_expValid <= 1'b0;
        end
    end

    assign w_capByte = i_slot_rdata[{w_capSlot, 3'b000} +: 8];

    always_ff @(posedge i_clk_sys) begin
        if (!i_reset_n) begin
            r_rdata      <= 8'h00;
            r_rdataValid <= 1'b0;
        end else begin
            r_rdataValid <= w_cap;
            if (w_cap) begin
                r_rdata <= w_capByte;
            end
        end
    end

    assign o_exp_owner   = r_expOwner;
    assign o_exp_valid   = r_expValid;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdataValid;

endmodule

// File: tb/tb_slot_bus_ctrl.sv
// Testbench for slot_bus_ctrl: two instances (STROBE_LEN 2 with mask $FE,
// STROBE_LEN 3 with mask $7E) driven by the same bus, each compared every
// cycle against a timeline model of the select pulses, ownership and reads.
module tb_slot_bus_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        phaseCe;
    logic [7:0]  bank;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  sltromsel;
    logic        intcxrom;
    logic [63:0] slotRdata;

    logic [7:0]  dev [2];
    logic [7:0]  ioSel [2];
    logic [7:0]  stb [2];
    logic        romCe [2];
    logic        slotCe [2];
    logic [2:0]  expOwner [2];
    logic        expValid [2];
    logic [7:0]  rdata [2];
    logic        rdataValid [2];

    int total = 0;
    int bad = 0;

    int         lenP [2] = '{2, 3};
    logic [7:0] maskP [2] = '{8'hFE, 8'h7E};

    // Model: each pulse is remembered as the span of edges after which it is visible.
    int         edgeN = 0;
    int         selStart [2];
    int         selEnd [2];
    int         kindM [2];
    int         slotM [2];
    int         validEdge [2];
    int         validSlot [2];
    int         ownerM [2];
    bit         ownValid [2];
    logic [7:0] rdM [2];
    bit         validNow [2];

    always #5 clk = ~clk;

    slot_bus_ctrl #(.NSLOTS(8), .SLOT_MASK(8'hFE), .STROBE_LEN(2)) u_dut2 (
        .i_clk_sys(clk), .i_reset_n(resetN), .i_phase_ce(phaseCe), .i_bank(bank),
        .i_addr(addr), .i_we(we), .i_sltromsel(sltromsel), .i_intcxrom(intcxrom),
        .i_slot_rdata(slotRdata), .o_device_select(dev[0]), .o_io_select(ioSel[0]),
        .o_io_strobe(stb[0]), .o_int_rom_ce(romCe[0]), .o_slot_ce(slotCe[0]),
        .o_exp_owner(expOwner[0]), .o_exp_valid(expValid[0]), .o_rdata(rdata[0]),
        .o_rdata_valid(rdataValid[0])
    );

    slot_bus_ctrl #(.NSLOTS(8), .SLOT_MASK(8'h7E), .STROBE_LEN(3)) u_dut3 (
        .i_clk_sys(clk), .i_reset_n(resetN), .i_phase_ce(phaseCe), .i_bank(bank),
        .i_addr(addr), .i_we(we), .i_sltromsel(sltromsel), .i_intcxrom(intcxrom),
        .i_slot_rdata(slotRdata), .o_device_select(dev[1]), .o_io_select(ioSel[1]),
        .o_io_strobe(stb[1]), .o_int_rom_ce(romCe[1]), .o_slot_ce(slotCe[1]),
        .o_exp_owner(expOwner[1]), .o_exp_valid(expValid[1]), .o_rdata(rdata[1]),
        .o_rdata_valid(rdataValid[1])
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit extM(input int i, input int s);
        return (s != 0) && (s < 8) && maskP[i][s] && sltromsel[s];
    endfunction

    // Claim rules straight from the slot map: kind 0 DEVSEL, 1 IOSEL, 2 IOSTROBE, -1 none.
    function automatic void decodeM(input int i, output int kind, output int slot,
                                    output bit eRom, output bit eSlot);
        int s;
        kind = -1; slot = 0; eRom = 1'b0; eSlot = 1'b0;
        if (!(bank == 8'h00 || bank == 8'h01 || bank == 8'hE0 || bank == 8'hE1)) return;
        if (addr >= 16'hC090 && addr <= 16'hC0FF) begin
            s = (int'(addr) - 'hC080) / 16;
            if (extM(i, s)) begin kind = 0; slot = s; eSlot = 1'b1; end
        end else if (addr >= 16'hC100 && addr <= 16'hC7FF) begin
            s = (int'(addr) - 'hC000) / 256;
            if (!intcxrom && extM(i, s)) begin kind = 1; slot = s; eSlot = 1'b1; end
            else eRom = 1'b1;
        end else if (addr >= 16'hC800 && addr <= 16'hCFFF) begin
            if (!intcxrom && ownValid[i] && extM(i, ownerM[i])) begin
                kind = 2; slot = ownerM[i]; eSlot = 1'b1;
            end else eRom = 1'b1;
        end
    endfunction

    // Advances the model across one rising edge using the inputs present at it.
    task automatic modelEdge();
        int k, s;
        bit r, c;
        edgeN++;
        for (int i = 0; i < 2; i++) begin
            validNow[i] = 1'b0;
            if (!resetN) begin
                selStart[i] = 0; selEnd[i] = -1; validEdge[i] = -1;
                ownerM[i] = 0; ownValid[i] = 1'b0; rdM[i] = 8'h00;
            end else begin
                decodeM(i, k, s, r, c);
                if (phaseCe && k >= 0) begin
                    selStart[i] = edgeN;
                    selEnd[i] = edgeN + lenP[i] - 1;
                    kindM[i] = k; slotM[i] = s;
                    validEdge[i] = we ? -1 : edgeN + lenP[i] - 1;
                    validSlot[i] = s;
                    if (k == 1) begin ownerM[i] = s; ownValid[i] = 1'b1; end
                end
                if (phaseCe && addr == 16'hCFFF &&
                    (bank == 8'h00 || bank == 8'h01 || bank == 8'hE0 || bank == 8'hE1))
                    ownValid[i] = 1'b0;
                if (edgeN == validEdge[i]) begin
                    validNow[i] = 1'b1;
                    rdM[i] = slotRdata[validSlot[i]*8 +: 8];
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic [7:0] eDev, eIo, eStb;
        for (int i = 0; i < 2; i++) begin
            eDev = '0; eIo = '0; eStb = '0;
            if (edgeN >= selStart[i] && edgeN <= selEnd[i]) begin
                if (kindM[i] == 0) eDev[slotM[i]] = 1'b1;
                else if (kindM[i] == 1) eIo[slotM[i]] = 1'b1;
                else eStb[slotM[i]] = 1'b1;
            end
            checkVal($sformatf("u%0d.device_select", i), dev[i], eDev);
            checkVal($sformatf("u%0d.io_select", i), ioSel[i], eIo);
            checkVal($sformatf("u%0d.io_strobe", i), stb[i], eStb);
            checkVal($sformatf("u%0d.exp_owner", i), expOwner[i], ownerM[i]);
            checkVal($sformatf("u%0d.exp_valid", i), expValid[i], ownValid[i]);
            checkVal($sformatf("u%0d.rdata", i), rdata[i], rdM[i]);
            checkVal($sformatf("u%0d.rdata_valid", i), rdataValid[i], validNow[i]);
        end
    endtask

    // One bus cycle: drive at the falling edge, check the enables, clock, check state.
    task automatic applyStimulus(input logic [7:0] b, input logic [15:0] a,
                                 input logic w, input logic p);
        int k, s;
        bit eRom, eSlot;
        bank = b; addr = a; we = w; phaseCe = p;
        #1;
        for (int i = 0; i < 2; i++) begin
            decodeM(i, k, s, eRom, eSlot);
            checkVal($sformatf("u%0d.int_rom_ce", i), romCe[i], eRom);
            checkVal($sformatf("u%0d.slot_ce", i), slotCe[i], eSlot);
        end
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) applyStimulus(8'h02, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            selStart[i] = 0; selEnd[i] = -1; validEdge[i] = -1; kindM[i] = 0;
            slotM[i] = 0; validSlot[i] = 0; ownerM[i] = 0; ownValid[i] = 1'b0;
            rdM[i] = 8'h00; validNow[i] = 1'b0;
        end
        resetN = 1'b0; phaseCe = 1'b0; bank = 8'h02; addr = 16'h0000; we = 1'b0;
        sltromsel = 8'h00; intcxrom = 1'b0;
        slotRdata = {$urandom, $urandom};

        idle(2);
        checkVal("rst.devsel", dev[0], 8'h00);
        checkVal("rst.exp_valid", expValid[0], 1'b0);
        checkVal("rst.rdata", rdata[0], 8'h00);
        resetN = 1'b1;
        idle(1);

        // DEVSEL read of slot 7; the $7E instance has no card there.
        sltromsel = 8'h80;
        applyStimulus(8'h00, 16'hC0F3, 1'b0, 1'b1);
        checkVal("tp1.devsel_c1", dev[0], 8'h80);
        checkVal("tp1.masked", dev[1], 8'h00);
        idle(1);
        checkVal("tp1.devsel_c2", dev[0], 8'h80);
        checkVal("tp1.rdvalid", rdataValid[0], 1'b1);
        checkVal("tp1.rdata", rdata[0], slotRdata[63:56]);
        idle(1);
        checkVal("tp1.devsel_end", dev[0], 8'h00);

        // IOSEL claims $C800 ownership, then IOSTROBE follows the owner.
        sltromsel = 8'h40;
        applyStimulus(8'hE1, 16'hC600, 1'b0, 1'b1);
        checkVal("tp2.iosel", ioSel[0], 8'h40);
        idle(3);
        checkVal("tp2.owner", expOwner[0], 3'd6);
        checkVal("tp2.valid", expValid[0], 1'b1);
        applyStimulus(8'h00, 16'hC900, 1'b0, 1'b1);
        checkVal("tp2.strobe", stb[0], 8'h40);
        idle(3);

        // $CFFF is serviced by the owner, then ownership is released.
        applyStimulus(8'h00, 16'hCFFF, 1'b0, 1'b1);
        checkVal("tp3.strobe", stb[0], 8'h40);
        checkVal("tp3.valid", expValid[0], 1'b0);
        idle(3);
        applyStimulus(8'h00, 16'hC900, 1'b0, 1'b1);
        checkVal("tp3.no_strobe", stb[0], 8'h00);
        idle(3);

        // Internal ROM override, then a non-I/O bank.
        applyStimulus(8'h00, 16'hC600, 1'b1, 1'b1);
        idle(3);
        intcxrom = 1'b1;
        applyStimulus(8'h00, 16'hC600, 1'b0, 1'b1);
        checkVal("tp4.no_iosel", ioSel[0], 8'h00);
        checkVal("tp4.owner", expOwner[0], 3'd6);
        applyStimulus(8'h02, 16'hC600, 1'b0, 1'b1);
        intcxrom = 1'b0;
        idle(2);

        // Back-to-back IOSEL: slot 4 is truncated, slot 5 runs its full length.
        sltromsel = 8'h30;
        applyStimulus(8'h00, 16'hC400, 1'b0, 1'b1);
        checkVal("tp5.iosel4", ioSel[1], 8'h10);
        applyStimulus(8'h00, 16'hC500, 1'b0, 1'b1);
        checkVal("tp5.iosel5", ioSel[1], 8'h20);
        idle(2);
        checkVal("tp5.rdvalid", rdataValid[1], 1'b1);
        checkVal("tp5.rdata", rdata[1], slotRdata[47:40]);
        idle(2);

        // Slot 0 area and a masked slot.
        sltromsel = 8'hFF;
        applyStimulus(8'h00, 16'hC080, 1'b0, 1'b1);
        checkVal("tp6.slot0", dev[0], 8'h00);
        applyStimulus(8'h00, 16'hC700, 1'b0, 1'b1);
        checkVal("tp6.mask_iosel", ioSel[1], 8'h00);
        idle(3);

        // Reset in the middle of a pulse.
        applyStimulus(8'h00, 16'hC300, 1'b0, 1'b1);
        resetN = 1'b0;
        idle(1);
        checkVal("tp6.rst_iosel", ioSel[1], 8'h00);
        checkVal("tp6.rst_valid", expValid[1], 1'b0);
        resetN = 1'b1;
        idle(1);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [7:0]  rb;
            logic [15:0] ra;
            case ($urandom_range(0, 5))
                0: rb = 8'h00;
                1: rb = 8'h01;
                2: rb = 8'hE0;
                3: rb = 8'hE1;
                4: rb = 8'h02;
                default: rb = 8'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0: ra = 16'hCFFF;
                1: ra = 16'($urandom);
                default: ra = 16'hC000 | 16'($urandom_range(0, 16'h0FFF));
            endcase
            if ($urandom_range(0, 4) == 0) sltromsel = 8'($urandom);
            intcxrom = ($urandom_range(0, 9) == 0);
            resetN = ($urandom_range(0, 99) != 0);
            slotRdata = {$urandom, $urandom};
            applyStimulus(rb, ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slot_bus_ctrl.md
Name: slot_bus_ctrl

Overview:
- Parametrised Apple II-style peripheral slot controller for the IIgs core; replaces the ad-hoc device/io select flags in the top level.
- Decodes CPU accesses to the I/O slot space in the I/O banks ($00, $01, $E0, $E1).
- Generates timed per-slot DEVSEL / IOSEL / IOSTROBE pulses and tracks $C800 expansion-ROM ownership.
- Muxes slot read data back to the CPU data-in path; supplies chip-enables for the internal-ROM vs external-slot choice.

Parameters:
- NSLOTS, 8, number of slot positions (slot index 0..NSLOTS-1; slot 0 never addressable as a card).
- SLOT_MASK, 8'hFE, bit s=1 means a card is fitted in slot s.
- STROBE_LEN, 2, width of each select pulse in clk_sys cycles (1..15).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- phase_ce  in  1  CPU access qualifier; the bus is sampled only when high.
- bank  in  8  CPU bank.
- addr  in  16  CPU address.
- we  in  1  write access.
- sltromsel  in  8  bit s=1 selects the external card ROM for slot s.
- intcxrom  in  1  forces the whole $C100-$CFFF range to internal ROM.
- slot_rdata  in  8*NSLOTS  packed card read data; slot s occupies bits [8s+7:8s].
- device_select  out  NSLOTS  DEVSEL pulse per slot.
- io_select  out  NSLOTS  IOSEL pulse per slot.
- io_strobe  out  NSLOTS  IOSTROBE pulse per slot ($C800-$CFFF).
- int_rom_ce  out  1  combinational: access hits internal ROM in $C100-$CFFF.
- slot_ce  out  1  combinational: access is claimed by an external card.
- exp_owner  out  3  current $C800 owner slot.
- exp_valid  out  1  exp_owner is valid.
- rdata  out  8  registered read data from the active slot.
- rdata_valid  out  1  one-cycle pulse when rdata updates.

Behaviour:
- io_bank = bank is one of $00, $01, $E0, $E1. No region decodes outside io_bank.
- ext(s) = SLOT_MASK[s] & sltromsel[s] & (s != 0).
- Decode is combinational on bank/addr. Every strobe, ownership and rdata update requires phase_ce=1.
- Region $C090-$C0FF: s = addr[6:4].
  - If ext(s): slot_ce=1 and device_select[s] pulses.
  - Otherwise no claim.
- Region $C100-$C7FF: s = addr[10:8].
  - If intcxrom=0 and ext(s): slot_ce=1, io_select[s] pulses, exp_owner<=s, exp_valid<=1. A new owner overrides the existing one.
  - Otherwise: int_rom_ce=1 and ownership is unchanged.
- Region $C800-$CFFF:
  - If intcxrom=0 and exp_valid and ext(exp_owner): slot_ce=1 and io_strobe[exp_owner] pulses.
  - Otherwise: int_rom_ce=1.
  - An access to $CFFF is serviced by the current owner under the rules above; exp_valid then clears on the same edge. A $CFFF access with no owner leaves exp_valid=0.
- Pulse timing:
  - A qualifying access registers the select at the edge where phase_ce=1. The output is high from the next cycle for exactly STROBE_LEN cycles.
  - A new qualifying access during a pulse truncates the old pulse and restarts from the new access.
  - At most one select bit is high at any time across all three vectors.
- Read path:
  - On a read (we=0), the slot and source are latched at access time.
  - In the final cycle of the pulse: rdata <= slot_rdata[active slot] and rdata_valid pulses for 1 cycle.
  - Writes and truncated pulses produce no rdata_valid.
- Reset (reset_n=0 at an edge): all select vectors 0, exp_owner=0, exp_valid=0, rdata=$00, rdata_valid=0, hold counter 0.
  - Reset mid-pulse kills the pulse on the next cycle.
  - Combinational ce outputs still follow the decode, but with exp_valid=0 after reset.

Decomposition:
- Package slot_bus_pkg holds:
  - I/O bank constants $00/$01/$E0/$E1;
  - region bounds $C090, $C100, $C800, $CFFF;
  - the select-kind enum (DEV, IO, STB);
  - the STROBE_LEN counter width function.
- One sub-module, slot_strobe_gen: the hold counter plus one-hot select register, reused for all three kinds via a kind input.

Test Plan:
- Reset, then a phase_ce read at $00:C0F3 with sltromsel=$80 -> device_select=$80 for 2 cycles starting 1 cycle later; rdata=slot_rdata[7] with rdata_valid on the 2nd cycle.
- Read at $E1:C600 with sltromsel=$40 -> io_select[6] pulses, exp_owner=6, exp_valid=1. Then a read at $00:C900 -> io_strobe[6] pulses and slot_ce=1.
- Owner 6, then an access to $00:CFFF -> io_strobe[6] pulses, exp_valid=0. Then $C900 -> int_rom_ce=1 and no strobe.
- intcxrom=1 with an access to $00:C600 -> int_rom_ce=1, no io_select, exp_owner unchanged. Same access at bank $02 -> nothing decoded.
- Access at $C400 then at $C500 one cycle later, STROBE_LEN=3 -> io_select[4] high for 1 cycle only, then io_select[5] for 3 cycles; only slot 5 gives rdata_valid.
- Slot 0 ($C080) or a masked slot (SLOT_MASK bit 0) -> no pulses. reset_n low mid-pulse -> all outputs 0 on the next cycle.
